bcd_stopwatch_ctrl: RTL
=======================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 Parameter PRESCALE, default 10: clock cycles per count increment; legal range is 2 or more.
REQ-002 Parameter NDIG, default 4: number of cascaded BCD digits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_asyn  input  1  asynchronous, active-low reset.
REQ-005 start_stop  input  1  single-cycle request pulse: start or pause counting.
REQ-006 clear  input  1  single-cycle request pulse: zero the count and return to idle.
REQ-007 lap  input  1  single-cycle request pulse: toggle the display freeze.
REQ-008 count  output  4*NDIG  live BCD count; digit 0 occupies bits [3:0] and is least significant.
REQ-009 disp  output  4*NDIG  display value: the frozen snapshot while lap_active=1, otherwise equal to count.
REQ-010 running  output  1  high when state is RUN.
REQ-011 lap_active  output  1  display freeze is in effect.
REQ-012 overflow  output  1  high when state is OVF.

Function
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE and OVF, held in a registered state variable.
REQ-014 IDLE: start_stop -> RUN; clear keeps IDLE and is otherwise a no-op.
REQ-015 RUN: clear -> IDLE; otherwise start_stop -> PAUSE; otherwise a tick at terminal count (all digits 9) -> OVF.
REQ-016 PAUSE: clear -> IDLE; otherwise start_stop -> RUN; lap is ignored.
REQ-017 OVF: clear -> IDLE; start_stop and lap are ignored.
REQ-018 When clear and start_stop are asserted in the same cycle, clear SHALL win.
REQ-019 Prescaler, range 0..PRESCALE-1: advances only in RUN, holds in PAUSE, and is zeroed on clear or on entry to IDLE.
REQ-020 Tick SHALL be asserted when state is RUN and the prescaler equals PRESCALE-1; on a tick the prescaler returns to 0.
REQ-021 Latency: the first increment lands on the PRESCALE-th rising edge after the edge that samples start_stop in IDLE.
REQ-022 Increment rule: on a tick, digit 0 adds 1; a digit at 9 wraps to 0 and carries into the next digit; all digits update on the same edge.
REQ-023 At terminal count, a tick SHALL saturate count at all-9s and move the FSM to OVF; count never wraps to 0.
REQ-024 start_stop in RUN on the same edge as a tick: the increment is applied and the FSM enters PAUSE.
REQ-025 Lap: a lap pulse in RUN with lap_active=0 latches the current count into the snapshot and sets lap_active.
REQ-026 Lap: a lap pulse in RUN with lap_active=1 clears lap_active; counting is never stalled by lap.
REQ-027 clear SHALL zero count, the snapshot, the prescaler and lap_active on the same edge.
REQ-028 Entry to OVF SHALL clear lap_active.

Reset
REQ-029 While rst_asyn=0: state=IDLE, count=0, snapshot=0, prescaler=0, lap_active=0, running=0, overflow=0, disp=0.
REQ-030 Reset assertion SHALL take effect immediately, independent of clk, including mid-count.
REQ-031 Reset release SHALL be sampled synchronously; the first request is honoured on the first rising edge after release.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the BCD_MAX=9 constant and a helper for the all-9s terminal-count test.
REQ-033 Sub-module bcd_digit (inputs clk, rst_asyn, en, clr; outputs q[3:0], carry) SHALL be instantiated NDIG times with its carry chained into the next digit's en.
REQ-034 The FSM, prescaler and lap snapshot SHALL reside in bcd_stopwatch_ctrl.

Verification (PRESCALE=2, NDIG=4)
REQ-035 Reset then start_stop pulse -> count=0001 two edges later and 0010 after 20 cycles; running=1.
REQ-036 Start, run 18 cycles, start_stop, wait 10 cycles, start_stop -> count held at 0009 during PAUSE, then 0010 two cycles after resume.
REQ-037 Preload near 9999 via the run, tick at terminal count -> count stays 9999, overflow=1, and a later start_stop is ignored.
REQ-038 Start, lap at count 0005, run to 0012 -> disp=0005 while count=0012; second lap -> disp tracks count.
REQ-039 clear and start_stop in the same cycle during RUN -> state IDLE, count=0, lap_active=0.
REQ-040 rst_asyn driven low mid-cycle during RUN -> all outputs zero before the next clock edge.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl_pkg
// Purpose  : Shared definitions for the BCD stopwatch controller: FSM state
//            encoding, the BCD digit maximum and the all-9s terminal test.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_stopwatch_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVF   = 2'd3;

  // Largest value a single BCD digit can hold
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Widest counter the terminal-count helper can inspect (in digits)
  localparam int unsigned MAX_DIG = 16;

  // True when the low ndig digits of v are all at BCD_MAX. Callers
  // zero-extend their count into the fixed-width argument.
  function automatic logic all_nines(input logic [4*MAX_DIG-1:0] v,
                                     input int unsigned          ndig);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < MAX_DIG; i++) begin
      if ((i < ndig) && (v[4*i +: 4] != BCD_MAX)) r = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One cascadable BCD digit. Counts 0..9 when enabled, wraps to 0
//            and raises carry in the cycle it wraps.
// Ports    : clk      - clock, rising edge
//            rst_asyn - asynchronous active-low reset
//            en       - advance this digit on the next edge
//            clr      - synchronous clear (wins over en)
//            q        - current digit value
//            carry    - en while at 9; drives the next digit's en
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit (
  input  logic       clk,
  input  logic       rst_asyn,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);
  import bcd_stopwatch_ctrl_pkg::*;

  // Combinational carry so every digit of the chain updates on the same edge
  assign carry = en && (q == BCD_MAX);

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl
// Purpose  : Stopwatch controller with an NDIG-digit BCD counter advanced
//            once every PRESCALE clocks, start/pause, clear, lap freeze and
//            saturating overflow.
// Ports    : clk        - clock, rising edge
//            rst_asyn   - asynchronous active-low reset
//            start_stop - pulse: start or pause counting
//            clear      - pulse: zero the count and return to idle
//            lap        - pulse: toggle the display freeze (RUN only)
//            count      - live BCD count, digit 0 in bits [3:0]
//            disp       - frozen snapshot while lap_active, else count
//            running    - state is RUN
//            lap_active - display freeze in effect
//            overflow   - state is OVF
// Parameters: PRESCALE (>=2) clocks per increment, NDIG (1..16) digits
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl #(
  parameter int PRESCALE = 10,
  parameter int NDIG     = 4
) (
  input  logic              clk,
  input  logic              rst_asyn,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [4*NDIG-1:0] count,
  output logic [4*NDIG-1:0] disp,
  output logic              running,
  output logic              lap_active,
  output logic              overflow
);
  import bcd_stopwatch_ctrl_pkg::*;

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [PW-1:0]         presc;
  logic [4*NDIG-1:0]     snap;
  logic                  tick;
  logic                  terminal;
  logic                  ovf_entry;
  logic [NDIG-1:0]       en_dig;
  logic [NDIG-1:0]       carry_dig;
  logic                  unused_carry;
  logic [4*MAX_DIG-1:0]  count_ext;

  // --------------------------------------------------------------------------
  // Terminal-count detect and tick generation
  // --------------------------------------------------------------------------
  always_comb begin
    count_ext              = '0;
    count_ext[4*NDIG-1:0]  = count;
  end

  assign terminal  = all_nines(count_ext, NDIG);
  assign tick      = (state == ST_RUN) && (presc == PS_LAST);
  assign ovf_entry = (state == ST_RUN) && (state_nxt == ST_OVF);

  // --------------------------------------------------------------------------
  // Digit chain. Digit 0 is held off at terminal count so the count
  // saturates at all-9s instead of wrapping; the top carry is therefore
  // never used.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign en_dig[g] = tick && !terminal;
      end else begin : g_upper
        assign en_dig[g] = carry_dig[g-1];
      end

      bcd_digit u_digit (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .en       (en_dig[g]),
        .clr      (clear),
        .q        (count[4*g +: 4]),
        .carry    (carry_dig[g])
      );
    end
  endgenerate

  assign unused_carry = carry_dig[NDIG-1];

  // --------------------------------------------------------------------------
  // FSM. clear has priority over start_stop in every state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_stop && !clear) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear)                  state_nxt = ST_IDLE;
        else if (start_stop)        state_nxt = ST_PAUSE;
        else if (tick && terminal)  state_nxt = ST_OVF;
      end
      ST_PAUSE: begin
        if (clear)           state_nxt = ST_IDLE;
        else if (start_stop) state_nxt = ST_RUN;
      end
      ST_OVF: begin
        if (clear) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler: advances on every RUN edge (including the edge that pauses),
  // holds in PAUSE, zeroed whenever the FSM heads to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      presc <= '0;
    end else if (clear || (state_nxt == ST_IDLE)) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Lap snapshot. The snapshot captures the pre-increment count when a lap
  // coincides with a tick; entering OVF drops the freeze.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      snap       <= '0;
      lap_active <= 1'b0;
    end else if (clear) begin
      snap       <= '0;
      lap_active <= 1'b0;
    end else if (ovf_entry) begin
      lap_active <= 1'b0;
    end else if ((state == ST_RUN) && lap) begin
      if (!lap_active) begin
        snap       <= count;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  assign disp     = lap_active ? snap : count;
  assign running  = (state == ST_RUN);
  assign overflow = (state == ST_OVF);

endmodule
`default_nettype wire
